acc_dump_32: RTL
================

# acc_dump_32

Integrate-and-dump stage sitting directly downstream of the 2-cycle pipelined 32-bit adder. It consumes the adder's 32-bit unsigned `Rslt` stream, qualified by a valid strobe delayed 2 cycles upstream to align with the adder output. It sums a programmable number of consecutive valid samples (1..256) into a 40-bit accumulator and emits one registered result per frame with a single-cycle valid pulse. Frames run back-to-back with no dead cycles, and the accumulator width guarantees no overflow.

## Interface
Parameters:
- `LEN_W`, 8: width of frame-length control; frame length = `Dump_Len` + 1 (1..2^LEN_W).
- `IN_W`, 32: input sample width (unsigned).
- `ACC_W`, 40: accumulator/output width; must be ≥ `IN_W` + `LEN_W`.

Ports:
- `clk`, in, 1: single clock; all logic on rising edge.
- `rst`, in, 1: synchronous, active-high reset.
- `In_Data`, in, `IN_W`: sample (adder `Rslt`), unsigned.
- `In_Vld`, in, 1: `In_Data` valid this cycle.
- `Dump_Len`, in, `LEN_W`: frame length minus one; sampled only at frame start.
- `Flush`, in, 1: abort current frame, discard partial sum, no output.
- `Out_Data`, out, `ACC_W`: frame sum, registered, held until next dump.
- `Out_Vld`, out, 1: one-cycle pulse when `Out_Data` updates.
- `Busy`, out, 1: high while a frame is partially accumulated (state ACC).

## Operation
- Reset: state IDLE, `acc`=0, `cnt`=0, `len_q`=0, `Out_Data`=0, `Out_Vld`=0, `Busy`=0.
- State IDLE, `In_Vld`=1, `Flush`=0:
  - `len_q` ← `Dump_Len`, `acc` ← zero-extended `In_Data`, `cnt` ← 0.
  - If `Dump_Len`=0: `Out_Data` ← zero-extended `In_Data`, `Out_Vld` ← 1, stay IDLE.
  - Otherwise go to ACC.
- State ACC, `In_Vld`=1, `Flush`=0:
  - If `cnt`+1 = `len_q`: `Out_Data` ← `acc` + `In_Data`, `Out_Vld` ← 1, `acc` ← 0, go to IDLE.
  - Otherwise `acc` ← `acc` + `In_Data`, `cnt` ← `cnt`+1.
- `In_Vld`=0: state, `acc` and `cnt` hold. Gaps inside a frame are allowed.
- Arithmetic: unsigned and zero-extended to `ACC_W`. The maximum sum, 256 × (2^32−1), fits in 40 bits, so there is no wrap and no saturation logic.
- `Flush`=1, in any state: next state IDLE, `acc` ← 0, `cnt` ← 0, `Out_Vld` ← 0. `Out_Data` holds its last value. A sample presented in the same cycle is dropped. `Flush` has priority over `In_Vld` and over a completing dump, so no output is produced.
- A `Dump_Len` change mid-frame has no effect until the next frame start.
- `Busy` = (state == ACC), registered.
- Reset mid-frame behaves like `Flush` and additionally clears `Out_Data` to 0.

## Timing
- Latency: `Out_Vld` asserts on the clock edge after the cycle in which the last sample of the frame is accepted (1 cycle).
- `Out_Vld` is high for exactly one cycle per completed frame.
- Back-to-back: a sample in the cycle immediately after the final sample starts a new frame. With continuous `In_Vld`, frames of length N produce `Out_Vld` every N cycles.
- N=1 with continuous input: `Out_Vld` is high every cycle and `Out_Data` tracks `In_Data` delayed by 1 cycle.
- End-to-end from adder inputs: 2 cycles (adder) + 1 cycle (this block) after the last operand pair.
- No backpressure: the block always accepts `In_Vld`.

## Test plan
- Reset then frames with N=4 (`Dump_Len`=3), continuous input 1,2,3,4,10,20,30,40 -> `Out_Vld` pulses 1 cycle after samples 4 and 8, with `Out_Data`=10 then 100. No gap between frames; `Busy` low only in the cycle after each dump.
- N=256, 256 samples of 0xFFFFFFFF with random `In_Vld` gaps -> exactly one pulse, `Out_Data`=0xFF_FFFF_FF00, no intermediate pulses.
- N=1, continuous samples 5,6,7 -> `Out_Vld` high 3 consecutive cycles, `Out_Data`=5,6,7, `Busy` stays 0.
- N=4, three samples of 7, then `Flush` together with a 4th sample -> no `Out_Vld`, `Out_Data` unchanged. The next 4 samples of 1 -> `Out_Data`=4.
- `Dump_Len` changed from 3 to 1 after the first sample of a frame -> that frame completes after 4 samples and the following frame after 2.
- `rst` asserted mid-frame after 2 samples -> next cycle all outputs are 0. A subsequent N=2 frame of 3,4 -> `Out_Data`=7.

Source files
------------

// File: rtl/acc_dump_32.sv
// Integrate-and-dump stage: sums Dump_Len+1 consecutive valid samples into a
// wide accumulator and emits one registered result per frame.
module acc_dump_32 #(
  parameter int unsigned LEN_W = 8,
  parameter int unsigned IN_W  = 32,
  parameter int unsigned ACC_W = 40
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IN_W-1:0]  In_Data,
  input  logic             In_Vld,
  input  logic [LEN_W-1:0] Dump_Len,
  input  logic             Flush,
  output logic [ACC_W-1:0] Out_Data,
  output logic             Out_Vld,
  output logic             Busy
);

  typedef enum logic {IDLE, ACC} state_t;

  state_t           state, state_nx;
  logic [ACC_W-1:0] acc, acc_nx;
  logic [ACC_W-1:0] out_data, out_data_nx;
  logic             out_vld, out_vld_nx;
  logic [LEN_W-1:0] cnt, cnt_nx;
  logic [LEN_W-1:0] len_q, len_nx;
  logic [ACC_W-1:0] in_ext;
  logic [ACC_W-1:0] sum;
  logic [LEN_W-1:0] cnt_inc;

  assign in_ext  = ACC_W'(In_Data);
  assign sum     = acc + in_ext;
  assign cnt_inc = cnt + LEN_W'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      acc      <= '0;
      cnt      <= '0;
      len_q    <= '0;
      out_data <= '0;
      out_vld  <= 1'b0;
    end else begin
      state    <= state_nx;
      acc      <= acc_nx;
      cnt      <= cnt_nx;
      len_q    <= len_nx;
      out_data <= out_data_nx;
      out_vld  <= out_vld_nx;
    end
  end

  // Flush outranks both a new sample and a completing dump.
  always_comb begin
    state_nx    = state;
    acc_nx      = acc;
    cnt_nx      = cnt;
    len_nx      = len_q;
    out_data_nx = out_data;
    out_vld_nx  = 1'b0;
    if (Flush) begin
      state_nx = IDLE;
      acc_nx   = '0;
      cnt_nx   = '0;
    end else if (In_Vld) begin
      unique case (state)
        IDLE: begin
          len_nx = Dump_Len;
          acc_nx = in_ext;
          cnt_nx = '0;
          if (Dump_Len == '0) begin
            out_data_nx = in_ext;
            out_vld_nx  = 1'b1;
          end else begin
            state_nx = ACC;
          end
        end
        ACC: begin
          if (cnt_inc == len_q) begin
            out_data_nx = sum;
            out_vld_nx  = 1'b1;
            acc_nx      = '0;
            state_nx    = IDLE;
          end else begin
            acc_nx = sum;
            cnt_nx = cnt_inc;
          end
        end
        default: state_nx = IDLE;
      endcase
    end
  end

  assign Out_Data = out_data;
  assign Out_Vld  = out_vld;
  assign Busy     = (state == ACC);

endmodule
